// File: rtl/hack_alu_pkg.sv
// Shared types and constants for the multi-cycle Hack ALU.
package hack_alu_pkg;

  // Operation select carried on the op port.
  typedef enum logic [1:0] {
    HACK = 2'b00,
    MUL  = 2'b01,
    SHL  = 2'b10,
    SHR  = 2'b11
  } op_t;

  // Top-level control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit positions inside the six-bit Hack control word {zx,nx,zy,ny,f,no}.
  localparam int CTL_ZX = 5;
  localparam int CTL_NX = 4;
  localparam int CTL_ZY = 3;
  localparam int CTL_NY = 2;
  localparam int CTL_F  = 1;
  localparam int CTL_NO = 0;

  // Commonly used control words.
  localparam logic [5:0] CTL_AND  = 6'b000000;
  localparam logic [5:0] CTL_ADD  = 6'b000010;
  localparam logic [5:0] CTL_NEG1 = 6'b111010;
  localparam logic [5:0] CTL_ZERO = 6'b101010;
  localparam logic [5:0] CTL_ONE  = 6'b111111;

endpackage

// File: rtl/hack_alu_comb.sv
// Combinational Hack datapath: operand zero/negate, add-or-and select,
// and carry/overflow of the add. The preprocessed operands are also
// exported so the iterative modes start from the same x2/y2.
module hack_alu_comb
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctl,
  output logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] r,
  output logic             cy,
  output logic             ov
);

  logic [WIDTH-1:0] xz;
  logic [WIDTH-1:0] yz;
  logic [WIDTH:0]   sum;

  // Operand preprocessing, then add-or-and with carry and signed overflow.
  always_comb begin
    xz  = ctl[CTL_ZX] ? '0 : x;
    yz  = ctl[CTL_ZY] ? '0 : y;
    x2  = ctl[CTL_NX] ? ~xz : xz;
    y2  = ctl[CTL_NY] ? ~yz : yz;
    sum = {1'b0, x2} + {1'b0, y2};
    r   = ctl[CTL_F] ? sum[WIDTH-1:0] : (x2 & y2);
    cy  = ctl[CTL_F] & sum[WIDTH];
    // Overflow: both addends share a sign and the sum does not.
    ov  = ctl[CTL_F] & (x2[WIDTH-1] == y2[WIDTH-1]) & (sum[WIDTH-1] != x2[WIDTH-1]);
  end

endmodule

// File: rtl/hack_alu_mc.sv
// Multi-cycle Hack ALU: single-cycle HACK op plus iterative shift-add
// multiply and one-bit-per-cycle logical shifts behind valid/ready.
module hack_alu_mc
  import hack_alu_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op,
  input  logic [5:0]       ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  state_t                 state_reg, state_next;
  logic [SHAMT_W:0]       cnt_reg, cnt_next;
  // Low half is the multiplier (MUL) or the shifting value (SHL/SHR);
  // high half accumulates partial products for MUL and stays zero otherwise.
  logic [2*WIDTH-1:0]     acc_reg, acc_next;
  logic [WIDTH-1:0]       mcand_reg, mcand_next;
  op_t                    op_reg, op_next;
  logic                   no_reg, no_next;

  logic [WIDTH-1:0]       out_reg;
  logic                   zr_reg, ng_reg, cy_reg, ov_reg;

  logic [WIDTH-1:0]       x2, y2, hack_r;
  logic                   hack_cy, hack_ov;
  logic [SHAMT_W-1:0]     n;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_acc;
  logic                   accept;
  logic                   load_out, fin_no, fin_cy, fin_ov;
  logic [WIDTH-1:0]       fin_r, fin_out;

  hack_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .x   (x),
    .y   (y),
    .ctl (ctl),
    .x2  (x2),
    .y2  (y2),
    .r   (hack_r),
    .cy  (hack_cy),
    .ov  (hack_ov)
  );

  assign n         = y2[SHAMT_W-1:0];
  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;

  // One shift-add step: conditionally add multiplicand to the high half,
  // then shift the whole accumulator right, keeping the add carry.
  assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
  assign mul_acc = {mul_sum, acc_reg[WIDTH-1:1]};
  assign fin_out = fin_no ? ~fin_r : fin_r;

  // Next-state, iteration and result-capture decode.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    mcand_next = mcand_reg;
    op_next    = op_reg;
    no_next    = no_reg;
    load_out   = 1'b0;
    fin_no     = no_reg;
    fin_r      = '0;
    fin_cy     = 1'b0;
    fin_ov     = 1'b0;
    case (state_reg)
      BUSY: begin
        cnt_next = cnt_reg - 1'b1;
        case (op_reg)
          MUL:     acc_next = mul_acc;
          SHL:     acc_next = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], 1'b0};
          default: acc_next = {acc_reg[2*WIDTH-1:WIDTH], 1'b0, acc_reg[WIDTH-1:1]};
        endcase
        if (cnt_reg == (SHAMT_W+1)'(1)) begin
          load_out   = 1'b1;
          state_next = DONE;
          case (op_reg)
            MUL: begin
              fin_r  = mul_acc[WIDTH-1:0];
              fin_ov = |mul_acc[2*WIDTH-1:WIDTH];
            end
            SHL: begin
              fin_r  = acc_next[WIDTH-1:0];
              fin_cy = acc_reg[WIDTH-1];
            end
            default: begin
              fin_r  = acc_next[WIDTH-1:0];
              fin_cy = acc_reg[0];
            end
          endcase
        end
      end
      default: begin
        if ((state_reg == DONE) && out_ready) state_next = IDLE;
        if (accept) begin
          op_next    = op_t'(op);
          no_next    = ctl[CTL_NO];
          fin_no     = ctl[CTL_NO];
          acc_next   = {{WIDTH{1'b0}}, x2};
          mcand_next = y2;
          if (op_t'(op) == HACK) begin
            load_out   = 1'b1;
            fin_r      = hack_r;
            fin_cy     = hack_cy;
            fin_ov     = hack_ov;
            state_next = DONE;
          end else if (op_t'(op) == MUL) begin
            cnt_next   = (SHAMT_W+1)'(WIDTH);
            state_next = BUSY;
          end else if (n == '0) begin
            // Zero-length shift completes immediately with x2 unchanged.
            load_out   = 1'b1;
            fin_r      = x2;
            state_next = DONE;
          end else begin
            cnt_next   = {1'b0, n};
            state_next = BUSY;
          end
        end
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      mcand_reg <= '0;
      op_reg    <= HACK;
      no_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      mcand_reg <= mcand_next;
      op_reg    <= op_next;
      no_reg    <= no_next;
    end
  end

  // Result and flags, updated only on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg <= '0;
      zr_reg  <= 1'b0;
      ng_reg  <= 1'b0;
      cy_reg  <= 1'b0;
      ov_reg  <= 1'b0;
    end else if (load_out) begin
      out_reg <= fin_out;
      zr_reg  <= (fin_out == '0);
      ng_reg  <= fin_out[WIDTH-1];
      cy_reg  <= fin_cy;
      ov_reg  <= fin_ov;
    end
  end

  assign out = out_reg;
  assign zr  = zr_reg;
  assign ng  = ng_reg;
  assign cy  = cy_reg;
  assign ov  = ov_reg;

endmodule

// File: tb/tb_hack_alu_mc.sv
// Scoreboard bench for hack_alu_mc: expected results are queued on accept
// and compared when the result is handed over.
module tb_hack_alu_mc;
  import hack_alu_pkg::*;

  localparam int W  = 16;
  localparam int SW = $clog2(W);

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] x, y;
  logic [1:0]   op;
  logic [5:0]   ctl;
  logic         out_valid, out_ready;
  logic [W-1:0] out;
  logic         zr, ng, cy, ov;

  typedef struct packed {
    logic [W-1:0] val;
    logic         zr;
    logic         ng;
    logic         cy;
    logic         ov;
  } res_t;

  res_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hack_alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .op        (op),
    .ctl       (ctl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .cy        (cy),
    .ov        (ov)
  );

  // Reference model written directly from the arithmetic definition.
  function automatic res_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [5:0] c);
    logic [W-1:0]   x2, y2, r;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    int             sh;
    res_t           e;
    e  = '0;
    r  = '0;
    x2 = c[5] ? '0 : a;
    if (c[4]) x2 = ~x2;
    y2 = c[3] ? '0 : b;
    if (c[2]) y2 = ~y2;
    sh = int'(y2[SW-1:0]);
    case (o)
      2'b00: begin
        if (c[1]) begin
          s    = {1'b0, x2} + {1'b0, y2};
          r    = s[W-1:0];
          e.cy = s[W];
          e.ov = (x2[W-1] == y2[W-1]) && (r[W-1] != x2[W-1]);
        end else begin
          r = x2 & y2;
        end
      end
      2'b01: begin
        p    = {{W{1'b0}}, x2} * {{W{1'b0}}, y2};
        r    = p[W-1:0];
        e.ov = (p[2*W-1:W] != '0);
      end
      2'b10: begin
        r    = x2 << sh;
        e.cy = (sh > 0) ? x2[W-sh] : 1'b0;
      end
      default: begin
        r    = x2 >> sh;
        e.cy = (sh > 0) ? x2[sh-1] : 1'b0;
      end
    endcase
    e.val = c[0] ? ~r : r;
    e.zr  = (e.val == '0);
    e.ng  = e.val[W-1];
    return e;
  endfunction

  // Issue one request, wait for its result, check latency, busy stall and value.
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [5:0] c, input int want_lat);
    int   lat, waitc;
    bit   busy_ok;
    res_t e, got;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op = o; x = a; y = b; ctl = c;
    #1;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk); #1;
      waitc++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL %s_accept: in_ready=%0b required 1", name, in_ready);
    end
    exp_q.push_back(model(o, a, b, c));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x = W'($urandom); y = W'($urandom); op = 2'($urandom); ctl = 6'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!out_valid || lat != want_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d (out_valid=%0b) required %0d", name, lat, out_valid, want_lat);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL %s_busy_ready: in_ready went high before result, required 0", name);
    end
    checks++;
    got = {out, zr, ng, cy, ov};
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_result: scoreboard empty, got %h", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL %s_result: got {out,zr,ng,cy,ov}=%h_%b%b%b%b required %h_%b%b%b%b",
                 name, got.val, got.zr, got.ng, got.cy, got.ov, e.val, e.zr, e.ng, e.cy, e.ov);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; op = 2'b00; ctl = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    checks++;
    if ({out, zr, ng, cy, ov} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got out=%h flags=%b%b%b%b required all 0", out, zr, ng, cy, ov);
    end
    @(negedge clk);
  endtask

  task automatic test_hack();
    run_op("hack_5p3",      HACK, 16'd5,      16'd3, CTL_ADD,  1);
    run_op("hack_ovf",      HACK, 16'h7FFF,   16'd1, CTL_ADD,  1);
    run_op("hack_carry",    HACK, 16'hFFFF,   16'd1, CTL_ADD,  1);
    run_op("hack_and",      HACK, 16'hF0F0,   16'h3C3C, CTL_AND, 1);
    run_op("hack_neg1",     HACK, 16'h1234,   16'h5678, CTL_NEG1, 1);
    for (int i = 0; i < 4; i++)
      run_op("hack_rand", HACK, W'($urandom), W'($urandom), 6'($urandom), 1);
  endtask

  task automatic test_mul();
    run_op("mul_300",    MUL, 16'd300, 16'd300, 6'b000000, W + 1);
    run_op("mul_300_no", MUL, 16'd300, 16'd300, 6'b000001, W + 1);
    run_op("mul_small",  MUL, 16'd123, 16'd45,  6'b000010, W + 1);
    run_op("mul_rand",   MUL, W'($urandom), W'($urandom), 6'($urandom), W + 1);
  endtask

  task automatic test_shift();
    run_op("shl_8001",   SHL, 16'h8001, 16'd1, 6'b000000, 2);
    run_op("shr_00f0",   SHR, 16'h00F0, 16'd4, 6'b000000, 5);
    run_op("shr_zero",   SHR, 16'hBEEF, 16'd0, 6'b000000, 1);
    run_op("shl_max",    SHL, 16'h0003, 16'd0, 6'b000100, 16);
    run_op("shr_neg",    SHR, 16'hA5A5, 16'd7, 6'b010000, 8);
  endtask

  task automatic test_backpressure();
    res_t e, got;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = HACK; x = 16'd1234; y = 16'd4321; ctl = CTL_ADD;
    exp_q.push_back(model(HACK, 16'd1234, 16'd4321, CTL_ADD));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    e = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      got = {out, zr, ng, cy, ov};
      checks++;
      if (!out_valid || in_ready || got !== e) begin
        failures++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b got %h required valid=1 ready=0 %h",
                 i, out_valid, in_ready, got, e);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op = HACK; x = 16'h0F0F; y = 16'h00FF; ctl = CTL_AND;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %b required 1", in_ready);
    end
    got = {out, zr, ng, cy, ov};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL bp_first_result: got %h required %h", got, e);
    end
    exp_q.push_back(model(HACK, 16'h0F0F, 16'h00FF, CTL_AND));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    got = {out, zr, ng, cy, ov};
    checks++;
    if (!out_valid || exp_q.size() == 0) begin
      failures++;
      $display("FAIL bp_second_valid: out_valid=%b required 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL bp_second_valid: got %h required %h", got, e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    res_t e, got;
    logic [W-1:0] a, b;
    logic [5:0]   c;
    int           cyc;
    out_ready = 1'b1;
    cyc = 0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        got = {out, zr, ng, cy, ov};
        checks++;
        if (!out_valid || exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_valid%0d: out_valid=%b required 1", i, out_valid);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL b2b_result%0d: got %h required %h", i, got, e);
          end
        end
      end
      if (i < 10) begin
        a = W'($urandom); b = W'($urandom); c = 6'($urandom);
        in_valid = 1'b1; op = HACK; x = a; y = b; ctl = c;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready%0d: got %b required 1", i, in_ready);
        end
        exp_q.push_back(model(HACK, a, b, c));
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != 11 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: cycles=%0d out_valid=%b pending=%0d required 11,0,0",
               cyc, out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_mul();
    bit stale;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op = MUL; x = 16'd300; y = 16'd300; ctl = 6'b000000;
    exp_q.push_back(model(MUL, 16'd300, 16'd300, 6'b000000));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_hs: out_valid=%b in_ready=%b required 0,1", out_valid, in_ready);
    end
    checks++;
    if ({out, zr, ng, cy, ov} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got out=%h flags=%b%b%b%b required all 0", out, zr, ng, cy, ov);
    end
    reset = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL rst_mid_stale: out_valid seen after reset, required none");
    end
    run_op("rst_then_add", HACK, 16'd2, 16'd2, CTL_ADD, 1);
  endtask

  initial begin
    test_reset();
    test_hack();
    test_mul();
    test_shift();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hack_alu_mc.md
# hack_alu_mc

Parametrised, multi-cycle successor to the Hack ALU. It keeps the six Hack control bits and zr/ng flags. It adds generic WIDTH, a valid/ready handshake, carry and overflow flags, and two iterative modes: shift-add multiply and logical shift. It sits between the CPU decode stage and the D/A/M writeback path, where the CPU stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 16: operand/result width, ≥2.
- `SHAMT_W`, $clog2(WIDTH): derived shift-amount width; not overridden.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at the rising edge.
- `x`, `y`  in  WIDTH  operands.
- `op`  in  2  00 HACK, 01 MUL, 10 SHL, 11 SHR.
- `ctl`  in  6  {zx,nx,zy,ny,f,no}, bit 5 = zx.
- `out_valid`  out  1  result held until `out_ready`.
- `out_ready`  in  1  consumer accepts.
- `out`  out  WIDTH  result.
- `zr`, `ng`, `cy`, `ov`  out  1 each  zero, negative, carry, overflow.

## Operation
- Operand preprocessing in every mode, latched at accept:
  - `x2 = nx ? ~(zx?0:x) : (zx?0:x)`.
  - `y2` is formed the same way from `y`, `zy` and `ny`.
- HACK mode:
  - `r = f ? x2+y2 : x2&y2`, computed mod 2^WIDTH.
  - `cy` = carry out of bit WIDTH-1 when f=1, else 0.
  - `ov` = signed add overflow, i.e. x2, y2 same sign and r of differing sign, when f=1, else 0.
- MUL mode:
  - Unsigned shift-add over 2·WIDTH accumulator, one multiplier bit per cycle, WIDTH iterations.
  - `r` = low WIDTH bits of the product.
  - `ov` = 1 iff the high WIDTH bits are nonzero.
  - `cy` = 0.
  - `f` is ignored.
- SHL/SHR modes:
  - Logical shift of x2 by n = y2[SHAMT_W-1:0], one bit per cycle.
  - `cy` = last bit shifted out; 0 when n=0.
  - `ov` = 0.
  - `f` is ignored.
- Output stage, all modes:
  - `out = no ? ~r : r`.
  - `zr = (out==0)`.
  - `ng = out[WIDTH-1]`.
  - `cy` and `ov` are computed before `no` and are not inverted.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: accept when `in_valid` is high. HACK, or a shift with n=0, goes to DONE; MUL, or a shift with n>0, goes to BUSY.
  - BUSY: iteration counter decrements each cycle. Goes to DONE on the cycle that performs the final iteration.
  - DONE: `out_valid`=1 and outputs are stable. On `out_ready`: if `in_valid` is also high, accept the new request and leave as IDLE would; otherwise go to IDLE.
- `in_ready` = IDLE || (DONE && out_ready). It is 0 in BUSY.
- Inputs are don't-care when not accepted; no input is sampled after the accept edge.

## Timing
- Reset values: state IDLE, `out`=0, `zr`=0, `ng`=0, `cy`=0, `ov`=0, `out_valid`=0, and `in_ready`=1 from the first cycle after reset.
- Accept at edge k:
  - HACK, or shift with n=0: `out_valid` from edge k+1.
  - MUL: `out_valid` from edge k+1+WIDTH, i.e. 17 cycles at 16 bits.
  - Shift with n>0: `out_valid` from edge k+1+n.
- Back-to-back throughput is one HACK result per cycle when `out_ready` is held high.
- `out` and the flags change only at the edge entering DONE or on reset. They hold while `out_ready`=0 for any duration.
- Reset asserted in any state, including mid-BUSY:
  - Next edge: IDLE, with all outputs at reset values.
  - The in-flight operation is discarded with no result.
- Reset has priority over a simultaneous accept.

## Structure
- Package `hack_alu_pkg`:
  - `op_t` enum: HACK, MUL, SHL, SHR.
  - `state_t` enum: IDLE, BUSY, DONE.
  - Control-bit index constants CTL_ZX…CTL_NO.
  - Named ctl constants, at minimum CTL_ADD=6'b000010, CTL_AND=6'b000000, CTL_NEG1=6'b111010.
- Sub-module `hack_alu_comb #(WIDTH)`: combinational preprocessing, f-select and carry/overflow. Instantiated once for HACK; its preprocessing also feeds MUL/SHL/SHR.
- Top level holds the FSM, the iteration counter (SHAMT_W+1 bits), the shift/accumulator registers and the output registers.

## Test plan
1. HACK, x=5, y=3, ctl=000010 -> `out`=8, zr=0, ng=0, cy=0, ov=0; `out_valid` one cycle after accept.
2. HACK add, x=16'h7FFF, y=1 -> `out`=16'h8000, ng=1, ov=1, cy=0. Then x=16'hFFFF, y=1 -> `out`=0, zr=1, cy=1, ov=0.
3. MUL, x=300, y=300, ctl=0 -> `out`=16'h5F90, ov=1, cy=0; `out_valid` exactly 17 cycles after accept and `in_ready`=0 throughout BUSY. Repeat with no=1 -> `out`=16'hA06F, ov=1.
4. SHL, x=16'h8001, y=1 -> `out`=16'h0002, cy=1, latency 2. SHR, x=16'h00F0, y=4 -> `out`=16'h000F, cy=0, latency 5. SHR, y=0 -> `out`=x, cy=0, latency 1.
5. Backpressure:
   - Hold `out_ready`=0 for 5 cycles: `out` and flags stable, `in_ready`=0.
   - Then assert `out_ready` and `in_valid` together: next request accepted that edge.
   - Ten HACK ops streamed with `out_ready`=1 complete in 11 cycles.
6. Reset at cycle 8 of a MUL -> next edge `out_valid`=0, `in_ready`=1, `out`=0, all flags 0, no stale result emitted. The following HACK x=2, y=2 add returns 4.
